mmio_memory_unit: RTL and testbench
===================================

Name: mmio_memory_unit

Overview:
- Parametrised data-memory plus memory-mapped I/O unit for the MIPS pipeline MEM stage.
- Combines word-addressed RAM, N_IN input-port registers with sticky "fresh" status, N_OUT output-port registers with write strobes, and a status word.
- Reads are registered with a one-cycle valid handshake.
- Writes to I/O addresses never reach RAM.

Parameters:
- DATA_W, 32, data width
- ADDR_W, 10, byte address width; RAM depth = 2**(ADDR_W-2) words
- N_IN, 2, input port count (1..3)
- N_OUT, 2, output port count (1..4)
- IN_BASE, 10'h3E0, address of input port 0; port k at IN_BASE+4k
- STATUS_ADDR, 10'h3EC, status word address
- OUT_BASE, 10'h3F0, address of output port 0; port k at OUT_BASE+4k

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- addr  in  ADDR_W  byte address; bits [1:0] ignored
- wr_en  in  1  write request
- rd_en  in  1  read request
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data, valid when rd_valid=1
- rd_valid  out  1  read data valid, one cycle after accepted rd_en
- in_data  in  N_IN*DATA_W  external input buses, port k at slice k
- in_load  in  N_IN  per-port capture enable
- out_port  out  N_OUT*DATA_W  output port registers
- out_strobe  out  N_OUT  one-cycle pulse after port k is updated
- addr_err  out  1  one-cycle pulse after a write to a read-only or unmapped I/O address

Behaviour:
- Reset (async, rst=1): rd_data=0, rd_valid=0, all in-port regs=0, fresh=0, out_port=0, out_strobe=0, addr_err=0. RAM contents are not reset.
- Decode uses word-aligned addr. io_hit is set for any address >= IN_BASE.
- Sub-regions are IN_k, STATUS, OUT_k, or unmapped (io_hit with no match).
- ram_we = wr_en & ~io_hit. RAM index = addr[ADDR_W-1:2]; write is synchronous.
- Read latency is one cycle. With rd_en at edge T, rd_data and rd_valid=1 are presented after edge T+1.
- rd_valid=0 in cycles with no accepted read; rd_data holds its last value.
- Read source by region: RAM word; in-port reg k; status; out-port reg k (readback allowed); unmapped returns 0.
- Status word: bits [N_IN-1:0] = fresh, bits [15:8] = N_IN, bits [23:16] = N_OUT, all other bits 0.
- Input capture: in_load[k] loads in_data slice k into in-port reg k and sets fresh[k].
- Fresh clear: an accepted read of IN_k clears fresh[k].
- Simultaneous load and read of the same port: the read returns the old register value, fresh[k] stays 1, and the register takes the new value.
- Output write: wr_en to OUT_k loads wr_data into out_port k. out_strobe[k]=1 for exactly the following cycle.
- Back-to-back writes to the same port give consecutive strobe pulses.
- Write to IN_k, STATUS or unmapped: no state change, addr_err pulses for one cycle.
- wr_en and rd_en together at the same address: the read returns pre-write data (read-first); the write commits.
- Reset mid-operation clears a pending rd_valid immediately. No read completes after reset deasserts.
- Elaboration-time checks: N_IN<=3, N_OUT<=4, regions non-overlapping, and IN_BASE >= 4*N_IN.

Decomposition:
- mmio_pkg holds:
  - region enum: REG_RAM, REG_IN, REG_STATUS, REG_OUT, REG_UNMAPPED
  - default address constants
  - decode function returning {region, index}
- Sub-module mmio_ram: synchronous write, registered read-first read, parametrised by DATA_W and depth. It replaces the existing RAM in this unit.
- The output-port register bank stays inline (generate loop).

Test Plan:
- Write 32'hDEADBEEF to 10'h010, then read 10'h010 -> rd_valid=1 one cycle later with rd_data=32'hDEADBEEF. A prior read of 10'h010 returns the old value.
- Write 32'h55 to 10'h3F4 -> out_port[1]=32'h55 and out_strobe=2'b10 for one cycle. RAM word 10'h3F4>>2 is unchanged (read it back through a preloaded value).
- Pulse in_load[0] with in_data[0]=32'hA5 -> status read returns 32'h0002_0201. A read of 10'h3E0 returns 32'hA5, then the status read returns 32'h0002_0200.
- Same cycle in_load[1] with value 7 and read of 10'h3E4 (old value 3) -> rd_data=3 and fresh[1] stays 1. The next read returns 7 and clears fresh[1].
- Write to 10'h3EC and to 10'h3E8 -> addr_err pulses each time, and no RAM or register change.
- Assert rst in the cycle after rd_en -> rd_valid=0, out_port=0, fresh=0 immediately. Normal operation resumes after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module      : mmio_pkg
// Description : Shared types, default address map and address decoder for
//               the MEM-stage data memory / memory-mapped I/O unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    // Default address map (byte addresses, word aligned)
    localparam int c_DEF_IN_BASE     = 'h3E0;
    localparam int c_DEF_STATUS_ADDR = 'h3EC;
    localparam int c_DEF_OUT_BASE    = 'h3F0;

    // Upper bounds on port counts; the index field is sized for these
    localparam int c_MAX_IN  = 3;
    localparam int c_MAX_OUT = 4;

    typedef enum logic [2:0] {
        REG_RAM      = 3'd0,
        REG_IN       = 3'd1,
        REG_STATUS   = 3'd2,
        REG_OUT      = 3'd3,
        REG_UNMAPPED = 3'd4
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [1:0] index;
    } decode_t;

    // Classify a byte address. Everything at or above in_base is I/O space;
    // I/O addresses that match no register are reported as unmapped.
    function automatic decode_t mmio_decode(
        input logic [31:0] byte_addr,
        input int          in_base,
        input int          status_addr,
        input int          out_base,
        input int          n_in,
        input int          n_out
    );
        decode_t     dec;
        logic [31:0] a;
        a          = {byte_addr[31:2], 2'b00};
        dec.region = REG_RAM;
        dec.index  = 2'd0;
        if (a >= 32'(in_base)) begin
            dec.region = REG_UNMAPPED;
            for (int k = 0; k < c_MAX_IN; k++) begin
                if (k < n_in && a == 32'(in_base + 4 * k)) begin
                    dec.region = REG_IN;
                    dec.index  = 2'(k);
                end
            end
            if (a == 32'(status_addr)) begin
                dec.region = REG_STATUS;
            end
            for (int k = 0; k < c_MAX_OUT; k++) begin
                if (k < n_out && a == 32'(out_base + 4 * k)) begin
                    dec.region = REG_OUT;
                    dec.index  = 2'(k);
                end
            end
        end
        return dec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_ram.sv
// ============================================================================
// Module      : mmio_ram
// Description : Word RAM with synchronous write and registered read-first
//               read. Contents and read register are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write and read share the edge; the read samples the pre-write word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mmio_memory_unit.sv
// ============================================================================
// Module      : mmio_memory_unit
// Description : MEM-stage data RAM plus memory-mapped input ports (with
//               sticky fresh flags), output ports (with strobes) and a
//               status word. One-cycle registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_memory_unit
    import mmio_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int N_IN        = 2,
    parameter int N_OUT       = 2,
    parameter int IN_BASE     = c_DEF_IN_BASE,
    parameter int STATUS_ADDR = c_DEF_STATUS_ADDR,
    parameter int OUT_BASE    = c_DEF_OUT_BASE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_load,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic [N_OUT-1:0]        out_strobe,
    output logic                    addr_err
);

    localparam int c_DEPTH = 2 ** (ADDR_W - 2);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (N_IN < 1 || N_IN > c_MAX_IN) begin : g_chk_n_in
        $error("mmio_memory_unit: N_IN must be 1..3");
    end
    if (N_OUT < 1 || N_OUT > c_MAX_OUT) begin : g_chk_n_out
        $error("mmio_memory_unit: N_OUT must be 1..4");
    end
    if (DATA_W < 24) begin : g_chk_data_w
        $error("mmio_memory_unit: DATA_W must hold the 24-bit status word");
    end
    if (IN_BASE < 4 * N_IN) begin : g_chk_in_base
        $error("mmio_memory_unit: IN_BASE must be >= 4*N_IN");
    end
    if (IN_BASE + 4 * N_IN > STATUS_ADDR || STATUS_ADDR + 4 > OUT_BASE ||
        OUT_BASE + 4 * N_OUT > 2 ** ADDR_W) begin : g_chk_overlap
        $error("mmio_memory_unit: I/O regions overlap or exceed address space");
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    decode_t           w_dec;
    logic              w_io_hit;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_io_rdata;

    logic [DATA_W-1:0] r_in     [N_IN];
    logic              r_fresh  [N_IN];
    logic [DATA_W-1:0] r_out    [N_OUT];
    logic              r_strobe [N_OUT];
    logic              r_rd_valid;
    logic              r_rd_from_ram;
    logic [DATA_W-1:0] r_io_rdata;
    logic              r_addr_err;

    assign w_dec    = mmio_decode(32'(addr), IN_BASE, STATUS_ADDR, OUT_BASE, N_IN, N_OUT);
    assign w_io_hit = (w_dec.region != REG_RAM);
    assign w_ram_we = wr_en & ~w_io_hit;
    assign w_ram_re = rd_en & ~w_io_hit;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    mmio_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (c_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (addr[ADDR_W-1:2]),
        .i_wdata (wr_data),
        .o_rdata (w_ram_rdata)
    );

    // Status word: fresh flags in the low bits, port counts in bytes 1 and 2
    always_comb begin
        w_status        = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_status[k] = r_fresh[k];
        end
        w_status[15:8]  = 8'(N_IN);
        w_status[23:16] = 8'(N_OUT);
    end

    // Current-cycle value of the addressed I/O register (pre-update)
    always_comb begin
        w_io_rdata = '0;
        case (w_dec.region)
            REG_IN: begin
                for (int k = 0; k < N_IN; k++) begin
                    if (w_dec.index == 2'(k)) begin
                        w_io_rdata = r_in[k];
                    end
                end
            end
            REG_STATUS: begin
                w_io_rdata = w_status;
            end
            REG_OUT: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (w_dec.index == 2'(k)) begin
                        w_io_rdata = r_out[k];
                    end
                end
            end
            default: begin
                w_io_rdata = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input ports: load sets fresh; a read clears it unless a load collides
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_IN; k++) begin : g_in_port
        logic w_rd_hit;
        assign w_rd_hit = rd_en && (w_dec.region == REG_IN) && (w_dec.index == 2'(k));

        // Capture external bus and maintain the sticky fresh flag
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_in[k]    <= '0;
                r_fresh[k] <= 1'b0;
            end else if (in_load[k]) begin
                r_in[k]    <= in_data[k*DATA_W +: DATA_W];
                r_fresh[k] <= 1'b1;
            end else if (w_rd_hit) begin
                r_fresh[k] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output ports with one-cycle update strobes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_OUT; k++) begin : g_out_port
        logic w_wr_hit;
        assign w_wr_hit = wr_en && (w_dec.region == REG_OUT) && (w_dec.index == 2'(k));

        // Load the port register and pulse its strobe on the following cycle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out[k]    <= '0;
                r_strobe[k] <= 1'b0;
            end else begin
                r_strobe[k] <= w_wr_hit;
                if (w_wr_hit) begin
                    r_out[k] <= wr_data;
                end
            end
        end

        assign out_port[k*DATA_W +: DATA_W] = r_out[k];
        assign out_strobe[k]                = r_strobe[k];
    end

    // ------------------------------------------------------------------
    // Read pipeline: remember the source and the I/O value at accept time;
    // RAM data comes from the RAM's own read register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid    <= 1'b0;
            r_rd_from_ram <= 1'b0;
            r_io_rdata    <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_from_ram <= ~w_io_hit;
                r_io_rdata    <= w_io_rdata;
            end
        end
    end

    // Flag writes into I/O space that have no writable target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= wr_en && (w_dec.region == REG_IN ||
                                    w_dec.region == REG_STATUS ||
                                    w_dec.region == REG_UNMAPPED);
        end
    end

    assign rd_data  = r_rd_from_ram ? w_ram_rdata : r_io_rdata;
    assign rd_valid = r_rd_valid;
    assign addr_err = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_mmio_memory_unit.sv
// ============================================================================
// Module      : tb_mmio_memory_unit
// Description : Directed scoreboard bench for mmio_memory_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_memory_unit;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NI = 2;
    localparam int NO = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     addr;
    logic              wr_en;
    logic              rd_en;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NI*DW-1:0]  in_data;
    logic [NI-1:0]     in_load;
    logic [NO*DW-1:0]  out_port;
    logic [NO-1:0]     out_strobe;
    logic              addr_err;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [DW-1:0]     exp_q [$];

    mmio_memory_unit #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .N_IN   (NI),
        .N_OUT  (NO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .in_data    (in_data),
        .in_load    (in_load),
        .out_port   (out_port),
        .out_strobe (out_strobe),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read result is matched against the scoreboard
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %h expected no read", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        addr    = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        in_data = '0;
        in_load = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_out_port", out_port, 64'd0);
        chk("rst_out_strobe", 64'(out_strobe), 64'd0);
        chk("rst_addr_err", 64'(addr_err), 64'd0);
        rst = 1'b0;
        idle();

        // Status after reset: no fresh flags
        rd(10'h3EC, 32'h0002_0200);

        // RAM: read-first on simultaneous write/read, then new value
        wr(10'h010, 32'h1111_1111);
        addr    = 10'h010;
        wr_data = 32'hDEAD_BEEF;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        exp_q.push_back(32'h1111_1111);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd(10'h010, 32'hDEAD_BEEF);
        idle();
        chk("idle_rd_valid", 64'(rd_valid), 64'd0);
        chk("idle_rd_hold", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);

        // Output port 1 and strobe
        wr(10'h3F4, 32'h55);
        chk("out1_value", out_port, 64'h0000_0055_0000_0000);
        chk("out1_strobe", 64'(out_strobe), 64'h2);
        idle();
        chk("out1_strobe_end", 64'(out_strobe), 64'h0);
        rd(10'h3F4, 32'h55);

        // Back-to-back writes to port 0 give consecutive strobes
        wr(10'h3F0, 32'h1);
        chk("out0_strobe_a", 64'(out_strobe), 64'h1);
        wr(10'h3F0, 32'h2);
        chk("out0_strobe_b", 64'(out_strobe), 64'h1);
        chk("out_both", out_port, 64'h0000_0055_0000_0002);
        idle();
        chk("out0_strobe_end", 64'(out_strobe), 64'h0);

        // Input port 0 capture and fresh clear
        in_data[31:0] = 32'hA5;
        in_load       = 2'b01;
        idle();
        in_load       = 2'b00;
        rd(10'h3EC, 32'h0002_0201);
        rd(10'h3E0, 32'hA5);
        rd(10'h3EC, 32'h0002_0200);

        // Input port 1: load 3, then load 7 colliding with a read
        in_data[63:32] = 32'd3;
        in_load        = 2'b10;
        idle();
        in_load        = 2'b00;
        rd(10'h3EC, 32'h0002_0202);
        in_data[63:32] = 32'd7;
        in_load        = 2'b10;
        rd(10'h3E4, 32'd3);
        in_load        = 2'b00;
        rd(10'h3EC, 32'h0002_0202);
        rd(10'h3E4, 32'd7);
        rd(10'h3EC, 32'h0002_0200);

        // Writes to read-only / unmapped I/O
        wr(10'h3EC, 32'hFFFF_FFFF);
        chk("err_status", 64'(addr_err), 64'd1);
        idle();
        chk("err_clear", 64'(addr_err), 64'd0);
        wr(10'h3E8, 32'hFFFF_FFFF);
        chk("err_unmapped", 64'(addr_err), 64'd1);
        chk("err_no_strobe", 64'(out_strobe), 64'd0);
        wr(10'h3E0, 32'h1234_5678);
        chk("err_in_port", 64'(addr_err), 64'd1);
        rd(10'h3EC, 32'h0002_0200);
        rd(10'h3E0, 32'hA5);
        rd(10'h3E8, 32'h0);
        chk("err_out_kept", out_port, 64'h0000_0055_0000_0002);

        // Reset while a read result is outstanding
        in_data[31:0] = 32'h99;
        in_load       = 2'b01;
        idle();
        in_load       = 2'b00;
        addr          = 10'h3E0;
        rd_en         = 1'b1;
        @(posedge clk);
        #1;
        rd_en         = 1'b0;
        chk("pre_rst_valid", 64'(rd_valid), 64'd1);
        rst           = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_data", 64'(rd_data), 64'd0);
        chk("mid_rst_out", out_port, 64'd0);
        chk("mid_rst_strobe", 64'(out_strobe), 64'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        idle();
        chk("post_rst_valid", 64'(rd_valid), 64'd0);
        rd(10'h3EC, 32'h0002_0200);
        rd(10'h3E0, 32'h0);
        rd(10'h010, 32'hDEAD_BEEF);
        rd(10'h3F4, 32'h0);

        repeat (3) idle();
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
